// File: rtl/byte_add_dma.sv
// Single-master read-modify-write DMA: walks a byte window one bus word at a time
// and rewrites each enabled byte with add/sub (wrapping or saturating) of a fixed addend.
module byte_add_dma #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic [ADDR_WIDTH-1:0]                             base_addr,
    input  logic [ADDR_WIDTH-1:0]                             length,
    input  logic [7:0]                                        addend,
    input  logic [1:0]                                        mode,
    input  logic                                              run,
    output logic                                              waitrequest,
    output logic [ADDR_WIDTH-$clog2(DATA_WIDTH/8)-1:0]        amm_address,
    output logic                                              amm_read,
    output logic                                              amm_write,
    output logic [DATA_WIDTH/8-1:0]                           amm_byteenable,
    output logic [DATA_WIDTH-1:0]                             amm_writedata,
    input  logic [DATA_WIDTH-1:0]                             amm_readdata,
    input  logic                                              amm_readdatavalid,
    input  logic                                              amm_waitrequest
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LB    = $clog2(BYTES);
    localparam int WA    = ADDR_WIDTH - LB;

    typedef enum logic [1:0] {IDLE, READ_REQ, READ_WAIT, WRITE} state_t;

    state_t                  state_q;
    logic                    busy_q, rd_q, wr_q;
    logic [WA-1:0]           addr_q;
    logic [BYTES-1:0]        be_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [ADDR_WIDTH-1:0]   base_q, len_q;
    logic [7:0]              addend_q;
    logic [1:0]              mode_q;
    logic [ADDR_WIDTH:0]     left_q;

    logic [ADDR_WIDTH:0]     words_d;
    logic [BYTES-1:0]        be_d;
    logic [DATA_WIDTH-1:0]   wdata_d;
    logic [ADDR_WIDTH-1:0]   lane_addr, lane_off;

    function automatic logic [7:0] byte_op(input logic [7:0] b, input logic [7:0] a,
                                           input logic [1:0] m);
        logic [8:0] s;
        s = '0;
        case (m)
            2'd0: byte_op = b + a;
            2'd1: byte_op = b - a;
            2'd2: begin
                s = {1'b0, b} + {1'b0, a};
                byte_op = s[8] ? 8'hFF : s[7:0];
            end
            default: begin
                s = {1'b0, b} - {1'b0, a};
                byte_op = s[8] ? 8'h00 : s[7:0];
            end
        endcase
    endfunction

    // Words touched = ceil((offset within first word + length) / BYTES).
    assign words_d = ({1'b0, length} + (ADDR_WIDTH+1)'(base_addr[LB-1:0])
                      + (ADDR_WIDTH+1)'(BYTES - 1)) >> LB;

    // A lane is inside the window when its distance from base (mod 2^ADDR_WIDTH) is below length.
    always_comb begin
        be_d      = '0;
        wdata_d   = amm_readdata;
        lane_addr = '0;
        lane_off  = '0;
        for (int k = 0; k < BYTES; k++) begin
            lane_addr = {addr_q, LB'(k)};
            lane_off  = lane_addr - base_q;
            if (lane_off < len_q) begin
                be_d[k]           = 1'b1;
                wdata_d[8*k +: 8] = byte_op(amm_readdata[8*k +: 8], addend_q, mode_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            base_q   <= '0;
            len_q    <= '0;
            addend_q <= '0;
            mode_q   <= '0;
            left_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // busy_q can only be high here for the single cycle of a zero-length job.
                    busy_q <= 1'b0;
                    if (run && !busy_q) begin
                        busy_q   <= 1'b1;
                        base_q   <= base_addr;
                        len_q    <= length;
                        addend_q <= addend;
                        mode_q   <= mode;
                        if (length != '0) begin
                            addr_q  <= base_addr[ADDR_WIDTH-1:LB];
                            left_q  <= words_d;
                            rd_q    <= 1'b1;
                            state_q <= READ_REQ;
                        end
                    end
                end
                READ_REQ: begin
                    if (!amm_waitrequest) begin
                        rd_q    <= 1'b0;
                        state_q <= READ_WAIT;
                    end
                end
                READ_WAIT: begin
                    if (amm_readdatavalid) begin
                        wdata_q <= wdata_d;
                        be_q    <= be_d;
                        wr_q    <= 1'b1;
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    if (!amm_waitrequest) begin
                        wr_q   <= 1'b0;
                        left_q <= left_q - (ADDR_WIDTH+1)'(1);
                        addr_q <= addr_q + WA'(1);
                        if (left_q == (ADDR_WIDTH+1)'(1)) begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            rd_q    <= 1'b1;
                            state_q <= READ_REQ;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign waitrequest    = busy_q;
    assign amm_read       = rd_q;
    assign amm_write      = wr_q;
    assign amm_address    = addr_q;
    assign amm_byteenable = be_q;
    assign amm_writedata  = wdata_q;
endmodule

// File: tb/tb_byte_add_dma.sv
// Directed bench for byte_add_dma with a byte-array Avalon-MM slave model
// (optional random backpressure and read latency).
module tb_byte_add_dma;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] base_addr, length;
    logic [7:0]  addend;
    logic [1:0]  mode;
    logic        run;
    logic        waitrequest;
    logic [9:0]  amm_address;
    logic        amm_read, amm_write;
    logic [3:0]  amm_byteenable;
    logic [31:0] amm_writedata;
    logic [31:0] amm_readdata = '0;
    logic        amm_readdatavalid = 1'b0;
    logic        amm_waitrequest = 1'b0;

    always #5 clk = ~clk;

    byte_add_dma #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .base_addr(base_addr), .length(length),
        .addend(addend), .mode(mode), .run(run), .waitrequest(waitrequest),
        .amm_address(amm_address), .amm_read(amm_read), .amm_write(amm_write),
        .amm_byteenable(amm_byteenable), .amm_writedata(amm_writedata),
        .amm_readdata(amm_readdata), .amm_readdatavalid(amm_readdatavalid),
        .amm_waitrequest(amm_waitrequest)
    );

    logic [7:0]  mem [0:4095];
    logic [7:0]  snap [0:79];
    bit          rnd_mode = 1'b0;
    int          fix_lat = 1;
    bit          pend = 1'b0;
    int          pcnt = 0;
    logic [9:0]  paddr = '0;
    bit          prev_st = 1'b0;
    logic [47:0] prev_cmd = '0;
    int          stall_err = 0, outst_err = 0, both_err = 0, stall_cnt = 0, cmd_cycles = 0;
    logic [9:0]  wlog_a [$];
    logic [3:0]  wlog_be [$];
    logic [31:0] wlog_d [$];
    logic [9:0]  rlog_a [$];
    int          checks = 0, errors = 0;

    // Slave model: decisions are made mid-cycle and take effect at the next rising edge.
    always @(negedge clk) begin
        amm_readdatavalid = 1'b0;
        if (!rst_n) begin
            pend = 1'b0;
            prev_st = 1'b0;
            amm_waitrequest = 1'b0;
        end else begin
            if (prev_st && ({amm_read, amm_write, amm_address, amm_byteenable, amm_writedata} !== prev_cmd))
                stall_err++;
            if (amm_read && amm_write) both_err++;
            if (amm_read || amm_write) cmd_cycles++;
            if (pend) begin
                pcnt--;
                if (pcnt == 0) begin
                    for (int k = 0; k < 4; k++) amm_readdata[8*k +: 8] = mem[int'(paddr)*4 + k];
                    amm_readdatavalid = 1'b1;
                    pend = 1'b0;
                end
            end
            if (amm_read && pend) outst_err++;
            amm_waitrequest = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b0;
            if (amm_read && !amm_waitrequest) begin
                pend  = 1'b1;
                pcnt  = rnd_mode ? int'($urandom_range(1, 5)) : fix_lat;
                paddr = amm_address;
                rlog_a.push_back(amm_address);
            end
            if (amm_write && !amm_waitrequest) begin
                for (int k = 0; k < 4; k++)
                    if (amm_byteenable[k]) mem[int'(amm_address)*4 + k] = amm_writedata[8*k +: 8];
                wlog_a.push_back(amm_address);
                wlog_be.push_back(amm_byteenable);
                wlog_d.push_back(amm_writedata);
            end
            prev_st  = (amm_read || amm_write) && amm_waitrequest;
            if (prev_st) stall_cnt++;
            prev_cmd = {amm_read, amm_write, amm_address, amm_byteenable, amm_writedata};
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rd8(input int a);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = mem[(a + i) % 4096];
        return r;
    endfunction

    task automatic start_job(input logic [11:0] b, input logic [11:0] l,
                             input logic [7:0] a, input logic [1:0] m);
        @(negedge clk);
        base_addr = b; length = l; addend = a; mode = m; run = 1'b1;
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic wait_idle(output int busy);
        int n;
        busy = 0;
        n = 0;
        while (waitrequest && n < 2000) begin
            busy++;
            n++;
            @(negedge clk);
        end
        if (n >= 2000) check("timeout", 64'd1, 64'd0);
    endtask

    task automatic do_job(input logic [11:0] b, input logic [11:0] l,
                          input logic [7:0] a, input logic [1:0] m, output int busy);
        start_job(b, l, a, m);
        wait_idle(busy);
    endtask

    initial begin
        int busy, n0, r0, c0, s0, diffs, n;
        logic [1:0]  modes [4];
        logic [23:0] mexp [4];
        modes = '{2'd0, 2'd2, 2'd1, 2'd3};
        mexp  = '{24'h030001, 24'h03FFFF, 24'hFFFCFD, 24'h00FCFD};
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        rst_n = 1'b0; base_addr = '0; length = '0; addend = '0; mode = '0; run = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_waitreq", waitrequest, 1'b0);
        check("rst_read", amm_read, 1'b0);
        check("rst_write", amm_write, 1'b0);
        check("rst_addr", amm_address, 10'd0);
        check("rst_be", amm_byteenable, 4'd0);
        check("rst_wdata", amm_writedata, 32'd0);
        rst_n = 1'b1;

        // Aligned two-word window
        for (int i = 0; i < 8; i++) mem[16 + i] = 8'(i);
        n0 = wlog_a.size(); r0 = rlog_a.size();
        do_job(12'h010, 12'd8, 8'd1, 2'd0, busy);
        check("A_busy", busy, 6);
        check("A_nwr", wlog_a.size() - n0, 2);
        check("A_wa0", wlog_a[n0], 10'd4);
        check("A_wa1", wlog_a[n0+1], 10'd5);
        check("A_be0", wlog_be[n0], 4'hF);
        check("A_be1", wlog_be[n0+1], 4'hF);
        check("A_ra0", rlog_a[r0], 10'd4);
        check("A_ra1", rlog_a[r0+1], 10'd5);
        check("A_data", rd8(16), 64'h0807060504030201);
        check("A_edges", {mem[15], mem[24]}, 16'h0000);

        // Unaligned window spanning three words
        for (int i = 0; i < 12; i++) mem[i] = 8'(i);
        n0 = wlog_a.size();
        do_job(12'h003, 12'd6, 8'd1, 2'd0, busy);
        check("B_busy", busy, 9);
        check("B_nwr", wlog_a.size() - n0, 3);
        check("B_wa", {wlog_a[n0], wlog_a[n0+1], wlog_a[n0+2]}, {10'd0, 10'd1, 10'd2});
        check("B_be", {wlog_be[n0], wlog_be[n0+1], wlog_be[n0+2]}, {4'b1000, 4'hF, 4'b0001});
        check("B_wd0", wlog_d[n0], 32'h04020100);
        check("B_wd2", wlog_d[n0+2], 32'h0B0A0909);
        check("B_lo", rd8(0), 64'h0807060504020100);
        check("B_hi", {mem[11], mem[10], mem[9], mem[8]}, 32'h0B0A0909);

        // Operation modes
        for (int j = 0; j < 4; j++) begin
            mem[32] = 8'hFF; mem[33] = 8'hFE; mem[34] = 8'h01; mem[35] = 8'h77;
            do_job(12'h020, 12'd3, 8'd2, modes[j], busy);
            check($sformatf("C_mode%0d", modes[j]), {mem[35], mem[34], mem[33], mem[32]}, {8'h77, mexp[j]});
        end

        // 64-byte job, zero-wait reference then random backpressure/latency
        for (int i = 0; i < 80; i++) mem[256 + i] = 8'(i*7 + 3);
        do_job(12'h102, 12'd64, 8'h55, 2'd2, busy);
        check("D_busy", busy, 51);
        for (int i = 0; i < 80; i++) snap[i] = mem[256 + i];
        check("D_first", snap[2], 8'h66);
        check("D_below", snap[1], 8'h0A);
        check("D_above", snap[66], 8'hD1);
        check("D_sat", snap[25], 8'hFF);
        for (int i = 0; i < 80; i++) mem[256 + i] = 8'(i*7 + 3);
        s0 = stall_cnt;
        rnd_mode = 1'b1;
        do_job(12'h102, 12'd64, 8'h55, 2'd2, busy);
        rnd_mode = 1'b0;
        repeat (2) @(negedge clk);
        diffs = 0;
        for (int i = 0; i < 80; i++) if (mem[256 + i] !== snap[i]) diffs++;
        check("D_same", diffs, 0);
        check("D_stalled", stall_cnt > s0, 1'b1);

        // Zero length
        c0 = cmd_cycles;
        do_job(12'h300, 12'd0, 8'd1, 2'd0, busy);
        check("E_busy", busy, 1);
        check("E_nocmd", cmd_cycles - c0, 0);

        // Second run while busy is ignored
        for (int i = 0; i < 8; i++) mem[48 + i] = 8'(16 + i);
        for (int i = 0; i < 4; i++) mem[512 + i] = 8'h00;
        n0 = wlog_a.size();
        start_job(12'h030, 12'd8, 8'd1, 2'd0);
        @(negedge clk);
        base_addr = 12'h200; length = 12'd4; addend = 8'h80; run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        wait_idle(busy);
        check("F_busy", busy, 4);
        check("F_data", rd8(48), 64'h1817161514131211);
        check("F_other", {mem[515], mem[514], mem[513], mem[512]}, 32'h0);
        check("F_nwr", wlog_a.size() - n0, 2);
        repeat (3) @(negedge clk);
        check("F_idle", waitrequest, 1'b0);

        // Address wrap at the top of the address space
        mem[4094] = 8'h10; mem[4095] = 8'h20; mem[0] = 8'h30; mem[1] = 8'h40; mem[2] = 8'h55;
        n0 = wlog_a.size();
        do_job(12'hFFE, 12'd4, 8'd1, 2'd0, busy);
        check("G_wa", {wlog_a[n0], wlog_a[n0+1]}, {10'h3FF, 10'h000});
        check("G_be", {wlog_be[n0], wlog_be[n0+1]}, {4'b1100, 4'b0011});
        check("G_data", {mem[1], mem[0], mem[4095], mem[4094]}, 32'h41312111);
        check("G_keep", mem[2], 8'h55);

        // Asynchronous reset while waiting for read data
        fix_lat = 3;
        start_job(12'h050, 12'd4, 8'd1, 2'd0);
        n = 0;
        while (!amm_read && n < 20) begin n++; @(negedge clk); end
        check("H_readseen", amm_read, 1'b1);
        @(posedge clk);
        #1;
        check("H_busy_pre", waitrequest, 1'b1);
        rst_n = 1'b0;
        #1;
        check("H_rst_outs", {waitrequest, amm_read, amm_write, amm_address, amm_byteenable, amm_writedata}, 49'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) mem[64 + i] = 8'(i + 1);
        do_job(12'h040, 12'd4, 8'd3, 2'd0, busy);
        check("H_busy", busy, 5);
        check("H_data", {mem[67], mem[66], mem[65], mem[64]}, 32'h07060504);
        fix_lat = 1;

        check("stall_stable", stall_err, 0);
        check("one_outstanding", outst_err, 0);
        check("rd_wr_exclusive", both_err, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/byte_add_dma.md
# byte_add_dma

Parametrised read-modify-write engine that walks a byte window in Avalon-MM memory and applies a per-byte arithmetic operation (add/subtract, wrapping or saturating) with a run-time addend. It is the next generation of the byte incrementer: a configurable bus width, arbitrary byte alignment via byte enables, and an operation mode. It sits between the host control registers (base/length/run/busy) and the memory interconnect as a single-master DMA.

## Interface
- ADDR_WIDTH, 12: byte-address width; also the width of `length`.
- DATA_WIDTH, 32: memory data width; a multiple of 8. BYTES = DATA_WIDTH/8, a power of two.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- base_addr  in  ADDR_WIDTH  first byte address of the window.
- length  in  ADDR_WIDTH  window size in bytes.
- addend  in  8  operand applied to every byte.
- mode  in  2  0 = add mod 256, 1 = sub mod 256, 2 = saturating add (clamps to 0xFF), 3 = saturating sub (clamps to 0x00).
- run  in  1  start pulse.
- waitrequest  out  1  busy flag; high while a job is active.
- amm_address  out  ADDR_WIDTH-log2(BYTES)  word address.
- amm_read / amm_write  out  1  Avalon-MM commands.
- amm_byteenable  out  BYTES  write lane enables.
- amm_writedata  out  DATA_WIDTH
- amm_readdata  in  DATA_WIDTH
- amm_readdatavalid  in  1
- amm_waitrequest  in  1  slave backpressure.

## Operation
- Reset values: waitrequest, amm_read, amm_write = 0; amm_address, amm_byteenable, amm_writedata = 0; FSM in IDLE.
- FSM states: IDLE -> READ_REQ -> READ_WAIT -> WRITE -> (READ_REQ for the next word | IDLE).
- IDLE: on run=1, latch base_addr, length, addend, mode. If length=0, assert waitrequest for exactly one cycle with no bus activity. Otherwise go to READ_REQ.
- Word range: first word = base_addr >> log2(BYTES); word count = ceil((base_addr mod BYTES + length) / BYTES). Word address increments by 1 and wraps modulo 2^(ADDR_WIDTH-log2(BYTES)).
- READ_REQ: amm_read=1, amm_address = current word. Leave on the cycle amm_waitrequest=0.
- READ_WAIT: wait for amm_readdatavalid, capture the result, compute writedata lane by lane.
- Byte lane k is enabled iff its byte address lies inside [base_addr, base_addr+length), computed modulo 2^ADDR_WIDTH. Enabled lanes carry op(byte, addend). Disabled lanes carry the original read byte and have byteenable=0.
- WRITE: amm_write=1 with address, data and byteenable. Leave on the cycle amm_waitrequest=0. Go to IDLE after the last word, else to READ_REQ.
- Arithmetic: 8-bit per lane. The saturating modes use a 9-bit intermediate.
- run is ignored while waitrequest=1. Inputs other than run are don't-care outside the run cycle.
- Only one read may be outstanding at a time. A readdatavalid seen outside READ_WAIT is ignored.
- rst_n low at any time forces the reset values immediately (asynchronously) and abandons the job. Partially written memory is not restored.

## Timing
- waitrequest rises the cycle after run is sampled. It falls the cycle after the final write is accepted.
- Per word, with zero wait states and read latency L: 1 (read) + L + 1 (write) cycles. Minimum 3 cycles per word at L=1.
- amm_read/amm_write, amm_address, amm_byteenable and amm_writedata stay stable while amm_waitrequest=1.
- amm_read and amm_write are never asserted in the same cycle.

## Test plan
- DATA_WIDTH=32; base 0x010, length 8, addend 1, mode 0; memory bytes 0x00..0x07 -> bytes become 0x01..0x08. Reads and writes hit words 4 and 5, each with byteenable 4'hF.
- Unaligned window: base 0x003, length 6 -> words 0, 1, 2 with byteenable 4'b1000, 4'hF, 4'b0001. Bytes 0x00-0x02 and 0x09-0x0B are unchanged.
- Mode coverage, bytes {0xFF, 0xFE, 0x01}, addend 2: mode 0 -> {0x01, 0x00, 0x03}; mode 2 -> {0xFF, 0xFF, 0x03}; mode 1 -> {0xFD, 0xFC, 0xFF}; mode 3 -> {0xFD, 0xFC, 0x00}.
- Random amm_waitrequest and read latency 1-5 on a 64-byte job -> final memory identical to the zero-wait run. Commands stay stable while stalled; at most one read is outstanding.
- length 0 -> waitrequest high for exactly 1 cycle, no amm_read or amm_write. A second run pulse mid-job -> ignored; the job completes once.
- Address wrap: base 0xFFE, length 4 (ADDR_WIDTH=12) -> word 0x3FF with byteenable 4'b1100, then word 0x000 with byteenable 4'b0011.
- rst_n pulsed low during READ_WAIT -> all outputs 0 the same cycle. A subsequent run then completes normally.
